// File: rtl/sipo_deser.sv
// sipo_deser: serial-in parallel-out frame deserializer with sof framing.
// Ports: clk, rst (sync active-low), ser_in/ser_vld/sof in; par_out,
// par_vld, busy, frm_err, par_err out. Define SIPO_PARITY_EN for a
// trailing even-parity bit per frame (par_err checks it; else tied 0).
module sipo_deser #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ser_in,
  input  logic             ser_vld,
  input  logic             sof,
  output logic [WIDTH-1:0] par_out,
  output logic             par_vld,
  output logic             busy,
  output logic             frm_err,
  output logic             par_err
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
`ifdef SIPO_PARITY_EN
    PARITY = 2'd2,
`endif
    SHIFT  = 2'd1
  } state_t;

  state_t           st;
  state_t           st_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_nxt;
  logic [WIDTH-1:0] first_w;
  logic [WIDTH-1:0] shift_w;
  logic             last;
  logic             start;
  logic             shift;
  logic             done;
  logic             ferr;

  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst) st <= IDLE;
    else      st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    unique case (st)
      IDLE: begin
        if (ser_vld && sof) st_nxt = SHIFT;
      end
      SHIFT: begin
        if (ser_vld && !sof && last)
`ifdef SIPO_PARITY_EN
          st_nxt = PARITY;
`else
          st_nxt = IDLE;
`endif
      end
`ifdef SIPO_PARITY_EN
      PARITY: begin
        if (ser_vld) st_nxt = sof ? SHIFT : IDLE;
      end
`endif
      default: st_nxt = IDLE;
    endcase
  end

  // A sof bit always opens a new frame; outside IDLE it also
  // aborts the partial one.
  always_comb begin
    start = ser_vld && sof;
    ferr  = start && (st != IDLE);
    shift = ser_vld && !sof && (st == SHIFT);
`ifdef SIPO_PARITY_EN
    done  = ser_vld && !sof && (st == PARITY);
`else
    done  = shift && last;
`endif
  end

  always_comb begin
    first_w = MSB_FIRST ? WIDTH'(ser_in)
                        : {ser_in, {(WIDTH-1){1'b0}}};
    shift_w = MSB_FIRST ? {sr[WIDTH-2:0], ser_in}
                        : {ser_in, sr[WIDTH-1:1]};
    sr_nxt  = sr;
    if (start)      sr_nxt = first_w;
    else if (shift) sr_nxt = shift_w;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt     <= '0;
      sr      <= '0;
      par_out <= '0;
      par_vld <= 1'b0;
      frm_err <= 1'b0;
    end else begin
      sr      <= sr_nxt;
      par_vld <= done;
      frm_err <= ferr;
      if (start)      cnt <= CW'(1);
      else if (done)  cnt <= '0;
      else if (shift) cnt <= cnt + CW'(1);
`ifdef SIPO_PARITY_EN
      if (done) par_out <= sr;
`else
      if (done) par_out <= sr_nxt;
`endif
    end
  end

`ifdef SIPO_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst) par_err <= 1'b0;
    else      par_err <= done && ((^sr) ^ ser_in);
  end
`else
  assign par_err = 1'b0;
`endif

  assign busy = (st != IDLE);

endmodule
